// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: unsigned binary to 4-digit packed BCD.
// Results appear on bcd/ovf only at the done edge, so a downstream display never sees partial values.
module bin2bcd_seq #(
  parameter int          BIN_W   = 16,
  parameter logic [15:0] SAT_VAL = 16'h9999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [15:0]      bcd
);

  localparam int SR_W  = 20 + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [SR_W-1:0] sr, sr_adj;
  logic [CNT_W-1:0] cnt;
  logic            ovf_next;
  logic            bin_big;

  // Five digits are adjusted so inputs up to 65535 convert correctly before saturation.
  always_comb begin
    sr_adj = sr;
    for (int d = 0; d < 5; d++)
      if (sr[BIN_W+4*d +: 4] >= 4'd5)
        sr_adj[BIN_W+4*d +: 4] = sr[BIN_W+4*d +: 4] + 4'd3;
  end

  generate
    if (BIN_W >= 14) begin : g_ovf
      assign bin_big = (32'(bin) > 32'd9999);
    end else begin : g_no_ovf
      assign bin_big = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      bcd      <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr       <= {20'b0, bin};
            cnt      <= '0;
            ovf_next <= bin_big;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sr_adj << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W-1)) state <= DONE;
        end
        DONE: begin
          bcd   <= ovf_next ? SAT_VAL : sr[BIN_W +: 16];
          ovf   <= ovf_next;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboarded bench for bin2bcd_seq: expected results are queued at start and popped at done.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] bin;
  logic        busy, done, ovf;
  logic [15:0] bcd;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [16:0] exp_q[$];

  bin2bcd_seq #(.BIN_W(16), .SAT_VAL(16'h9999)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .ovf(ovf), .bcd(bcd)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Called at a negedge; lat counts negedges until done is seen (18 for BIN_W=16), -1 on timeout.
  task automatic run_conv(input int v, output int lat, output int busy_n, output bit stable);
    logic [15:0] held;
    held = bcd; lat = -1; busy_n = 0; stable = 1'b1;
    exp_q.push_back(model(v));
    start = 1'b1; bin = 16'(v);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
      if (done) begin lat = n; break; end
      if (bcd !== held) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bin = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bcd !== 16'h0000) $display("FAIL reset_bcd got %h want 0000", bcd); else pass_cnt++;
    total_cnt++;
    if ({busy, done, ovf} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, ovf});
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bn; bit st; logic [16:0] e;
    run_conv(1234, lat, bn, st);
    e = exp_q.pop_front();
    total_cnt++;
    if (lat !== 18) $display("FAIL basic_latency got %0d want 18", lat); else pass_cnt++;
    total_cnt++;
    if (bn !== 17) $display("FAIL basic_busy_cycles got %0d want 17", bn); else pass_cnt++;
    total_cnt++;
    if ({ovf, bcd} !== e) $display("FAIL basic_result got %b_%h want %b_%h", ovf, bcd, e[16], e[15:0]);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, bn; bit st; logic [16:0] e;
    run_conv(0, lat, bn, st);
    e = exp_q.pop_front();
    total_cnt++;
    if ({ovf, bcd} !== e) $display("FAIL b2b_first got %b_%h want %b_%h", ovf, bcd, e[16], e[15:0]);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b1) $display("FAIL b2b_done_high got %b want 1", done); else pass_cnt++;
    run_conv(9999, lat, bn, st);
    e = exp_q.pop_front();
    total_cnt++;
    if (lat !== 18) $display("FAIL b2b_spacing got %0d want 18", lat); else pass_cnt++;
    total_cnt++;
    if ({ovf, bcd} !== e) $display("FAIL b2b_second got %b_%h want %b_%h", ovf, bcd, e[16], e[15:0]);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    int vals[3] = '{10000, 65535, 42};
    int lat, bn; bit st; logic [16:0] e;
    foreach (vals[i]) begin
      run_conv(vals[i], lat, bn, st);
      e = exp_q.pop_front();
      total_cnt++;
      if ({ovf, bcd} !== e)
        $display("FAIL sat_%0d got %b_%h want %b_%h", vals[i], ovf, bcd, e[16], e[15:0]);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_start_busy();
    int dn, at_n; logic [16:0] got, e;
    dn = 0; at_n = -1; got = '0;
    exp_q.push_back(model(5678));
    start = 1'b1; bin = 16'd5678;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      start = (n == 3);
      bin = (n == 3) ? 16'd1111 : 16'($urandom);
      if (done) begin dn++; at_n = n; got = {ovf, bcd}; end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    total_cnt++;
    if (dn !== 1) $display("FAIL busy_start_done_count got %0d want 1", dn); else pass_cnt++;
    total_cnt++;
    if (at_n !== 18) $display("FAIL busy_start_latency got %0d want 18", at_n); else pass_cnt++;
    total_cnt++;
    if (got !== e) $display("FAIL busy_start_result got %h want %h", got, e); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL busy_start_idle got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, bn, dn, bz; bit st; logic [16:0] e;
    run_conv(300, lat, bn, st);
    e = exp_q.pop_front();
    total_cnt++;
    if ({ovf, bcd} !== e) $display("FAIL rstmid_pre got %b_%h want %b_%h", ovf, bcd, e[16], e[15:0]);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b1; bin = 16'd777;
    for (int n = 1; n <= 8; n++) begin @(negedge clk); start = 1'b0; end
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, ovf, bcd} !== 19'h0)
      $display("FAIL rstmid_async got %b%b%b_%h want 000_0000", busy, done, ovf, bcd);
    else pass_cnt++;
    dn = 0; bz = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 3) rst_n = 1'b1;
      if (done) dn++;
      if (busy) bz++;
    end
    total_cnt++;
    if (dn !== 0 || bz !== 0) $display("FAIL rstmid_no_done got done=%0d busy=%0d want 0/0", dn, bz);
    else pass_cnt++;
    run_conv(777, lat, bn, st);
    e = exp_q.pop_front();
    total_cnt++;
    if (lat !== 18) $display("FAIL rstmid_latency got %0d want 18", lat); else pass_cnt++;
    total_cnt++;
    if ({ovf, bcd} !== e) $display("FAIL rstmid_post got %b_%h want %b_%h", ovf, bcd, e[16], e[15:0]);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    int v, lat, bn; bit st; logic [16:0] e;
    v = 0;
    while (1) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_conv(v, lat, bn, st);
      e = exp_q.pop_front();
      total_cnt++;
      if ({ovf, bcd} !== e || lat !== 18 || !st)
        $display("FAIL sweep_%0d got %b_%h lat=%0d stable=%0d want %b_%h lat=18 stable=1",
                 v, ovf, bcd, lat, st, e[16], e[15:0]);
      else pass_cnt++;
      if (v == 9999) break;
      v = (v + 7 > 9999) ? 9999 : v + 7;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturate();
    test_start_busy();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
